serial_frame_receiver: RTL and testbench

//  Receiving end of the shifter serial link: rebuilds WIDTH-bit parallel words from the s_out
//  bit stream of a multi-mode shifter. Supports both bit orders the transmitter produces.

---
 rtl/serial_frame_receiver.sv | 113 +++++++++++
 tb/tb_serial_frame_receiver.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/serial_frame_receiver.sv
// Serial-to-parallel receiver for the shifter link: assembles WIDTH-bit frames in either
// bit order and presents them through a one-word valid/ready holding register.
module serial_frame_receiver #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic             right_left,
    input  logic             s_in,
    input  logic             out_ready,
    input  logic             clr_overrun,
    output logic [WIDTH-1:0] p_out,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             order_q, order_d;
    logic [WIDTH-1:0] p_out_q, p_out_d;
    logic             out_valid_q, out_valid_d;
    logic             overrun_q, overrun_d;

    logic             new_frame;
    logic             take_bit;
    logic             frame_order;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    cnt_inc;
    logic             complete;
    logic             load;

    // A start strobe always opens a fresh frame from a cleared register, so a resync
    // mid-frame cannot leak bits of the abandoned word into the new one.
    assign new_frame   = enable && start;
    assign take_bit    = enable && (start || (state_q == SHIFT));
    assign frame_order = new_frame ? right_left : order_q;
    assign base        = new_frame ? '0 : sr_q;
    assign shifted     = frame_order ? {s_in, base[WIDTH-1:1]} : {base[WIDTH-2:0], s_in};
    assign cnt_inc     = new_frame ? CW'(1) : bit_cnt_q + CW'(1);
    assign complete    = take_bit && (cnt_inc == CW'(WIDTH));
    assign load        = complete && (!out_valid_q || out_ready);

    always_comb begin
        // NOTE: every _d gets a hold default first so no path through the if-tree infers a latch.
        state_d     = state_q;
        sr_d        = sr_q;
        bit_cnt_d   = bit_cnt_q;
        order_d     = order_q;
        p_out_d     = p_out_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;

        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (clr_overrun)              overrun_d   = 1'b0;

        if (take_bit) begin
            sr_d      = shifted;
            order_d   = frame_order;
            bit_cnt_d = cnt_inc;
            state_d   = SHIFT;
            if (complete) begin
                state_d   = IDLE;
                bit_cnt_d = '0;
                if (load) begin
                    p_out_d     = shifted;
                    out_valid_d = 1'b1;
                end else begin
                    // Drop is applied after the clear so a same-cycle drop keeps the flag set.
                    overrun_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (reset) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            order_q     <= 1'b0;
            p_out_q     <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            order_q     <= order_d;
            p_out_q     <= p_out_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign p_out     = p_out_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == SHIFT);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Scoreboard bench for serial_frame_receiver: expected words are queued as frames are sent
// and compared whenever the DUT hands a word over (out_valid & out_ready).
module tb_serial_frame_receiver;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic         start = 1'b0;
    logic         right_left = 1'b0;
    logic         s_in = 1'b0;
    logic         out_ready = 1'b0;
    logic         clr_overrun = 1'b0;
    logic [W-1:0] p_out;
    logic         out_valid;
    logic         busy;
    logic         overrun;

    logic         pulse_ready = 1'b0;
    logic [W-1:0] exp_q[$];
    int           n_vec = 0;
    int           n_err = 0;

    serial_frame_receiver #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .start      (start),
        .right_left (right_left),
        .s_in       (s_in),
        .out_ready  (out_ready),
        .clr_overrun(clr_overrun),
        .p_out      (p_out),
        .out_valid  (out_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Handover monitor: sampled on the falling edge, i.e. what the next rising edge will see.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("sb_spurious", 32'(p_out), 32'hFFFF_FFFF);
            else                   check("sb_word", 32'(p_out), 32'(exp_q.pop_front()));
        end
    end

    // Advance one cycle and drive the next set of inputs 1 time unit after the edge.
    task automatic drive(input logic en, input logic st, input logic rl, input logic b);
        @(posedge clk);
        #1;
        enable     = en;
        start      = st;
        right_left = rl;
        s_in       = b;
        if (pulse_ready) out_ready = out_valid;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input logic [W-1:0] word, input logic lsb_first, input int gap);
        for (int i = 0; i < W; i++) begin
            drive(1'b1, i == 0, lsb_first, lsb_first ? word[i] : word[W-1-i]);
            if (gap > 0) begin
                idle();
                check("busy_gap", 32'(busy), 32'(i != W - 1));
                for (int g = 1; g < gap; g++) idle();
            end
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_p_out", 32'(p_out), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overrun", 32'(overrun), 0);
        reset = 1'b0;

        // T1: MSB first 0xA5, consumer always ready
        out_ready = 1'b1;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b0, 0);
        idle();
        check("t1_valid", 32'(out_valid), 1);
        check("t1_p_out", 32'(p_out), 32'hA5);
        check("t1_busy", 32'(busy), 0);
        idle();
        check("t1_valid_drop", 32'(out_valid), 0);

        // T2: LSB first 0x3C with 3-cycle enable gaps
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 3);
        check("t2_p_out", 32'(p_out), 32'h3C);

        // T3: consumer stalled; second frame dropped (with clr_overrun held, set wins)
        out_ready = 1'b0;
        idle();
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b0, 0);
        clr_overrun = 1'b1;
        send_frame(8'hC3, 1'b0, 0);
        idle();
        clr_overrun = 1'b0;
        check("t3_overrun", 32'(overrun), 1);
        check("t3_p_out", 32'(p_out), 32'h5A);
        check("t3_valid", 32'(out_valid), 1);
        clr_overrun = 1'b1;
        idle();
        clr_overrun = 1'b0;
        check("t3_clr", 32'(overrun), 0);
        check("t3_hold", 32'(p_out), 32'h5A);
        out_ready = 1'b1;
        idle();
        idle();
        check("t3_consumed", 32'(out_valid), 0);

        // T4: partial frame abandoned by a resync start
        for (int i = 0; i < 5; i++) drive(1'b1, i == 0, 1'b0, 1'b1);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b0, 0);
        idle();
        check("t4_p_out", 32'(p_out), 32'h81);
        check("t4_overrun", 32'(overrun), 0);
        idle();

        // T5: reset mid-frame while a word is held and start/enable are active
        out_ready = 1'b0;
        send_frame(8'h66, 1'b0, 0);
        for (int i = 0; i < 4; i++) drive(1'b1, i == 0, 1'b0, 1'b1);
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        idle();
        check("t5_rst_p_out", 32'(p_out), 0);
        check("t5_rst_valid", 32'(out_valid), 0);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_overrun", 32'(overrun), 0);
        reset = 1'b0;
        out_ready = 1'b1;
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 1'b0, 0);
        idle();
        check("t5_p_out", 32'(p_out), 32'hFF);
        idle();

        // T6: back-to-back frames, ready pulsed only while a word is valid
        out_ready = 1'b0;
        pulse_ready = 1'b1;
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h80);
        send_frame(8'h01, 1'b0, 0);
        send_frame(8'h80, 1'b0, 0);
        idle();
        check("t6_p_out", 32'(p_out), 32'h80);
        repeat (3) idle();
        pulse_ready = 1'b0;
        check("t6_overrun", 32'(overrun), 0);
        check("t6_valid", 32'(out_valid), 0);

        check("sb_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
